// File: rtl/poly_lfsr_stream.sv
// Multi-lane parallel Fibonacci LFSR pattern generator with a valid/ready output stream.
// Optional word counter port is enabled by defining POLY_LFSR_STREAM_WORDCNT_EN.
module poly_lfsr_stream #(
   parameter int          WIDTH        = 32,
   parameter int          LANES        = 8,
   parameter int          STEP         = WIDTH,
   parameter logic [31:0] TAPS_DEFAULT = 32'h8020_0003,
   parameter int          COUNT_W      = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [WIDTH-1:0]         taps,
   input  logic [WIDTH-1:0]         seed,
   input  logic                     load,
   input  logic                     enable,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   q,
   output logic                     seed_err
`ifdef POLY_LFSR_STREAM_WORDCNT_EN
   ,
   output logic [COUNT_W-1:0]       word_cnt
`endif
);

   // Handshake: a beat transfers on any rising clk edge where out_valid && out_ready.
   // Once out_valid rises, q and out_valid hold until that transfer or a load/reset.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  s;
   logic [WIDTH-1:0]  taps_r;
   logic [WIDTH-1:0]  seed_eff;
   logic [WIDTH-1:0]  s_adv;
   logic              accept;

   function automatic logic [WIDTH-1:0] bit_step(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] t);
      return {x[WIDTH-2:0], ^(x & t)};
   endfunction

   function automatic logic [WIDTH-1:0] lane_step(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] t);
      logic [WIDTH-1:0] w;
      w = x;
      for (int i = 0; i < STEP; i++) w = bit_step(w, t);
      return w;
   endfunction

   function automatic logic [WIDTH-1:0] beat_step(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] t);
      logic [WIDTH-1:0] w;
      w = x;
      for (int k = 0; k < LANES; k++) w = lane_step(w, t);
      return w;
   endfunction

   function automatic logic [LANES*WIDTH-1:0] lanes_of(input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] t);
      logic [LANES*WIDTH-1:0] r;
      logic [WIDTH-1:0]       w;
      r = '0;
      w = x;
      for (int k = 0; k < LANES; k++) begin
         r[k*WIDTH +: WIDTH] = w;
         w = lane_step(w, t);
      end
      return r;
   endfunction

   // A zero state would lock the shifter, so a zero seed falls back to all ones.
   assign seed_eff = (seed == '0) ? '1 : seed;
   assign s_adv    = beat_step(s, taps_r);
   assign accept   = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (load || enable) state_d = RUN;
         end
         RUN: begin
            out_valid = 1'b1;
            if (load)         state_d = RUN;
            else if (!enable) state_d = accept ? IDLE : DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (load)        state_d = RUN;
            else if (accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Load takes priority over a same-cycle accept: the pending beat is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s        <= '1;
         taps_r   <= WIDTH'(TAPS_DEFAULT);
         q        <= '0;
         seed_err <= 1'b0;
      end else if (load) begin
         s        <= seed_eff;
         taps_r   <= taps;
         q        <= lanes_of(seed_eff, taps);
         seed_err <= (seed == '0);
      end else if (accept) begin
         s <= s_adv;
         q <= lanes_of(s_adv, taps_r);
      end else if (state_q == IDLE && enable) begin
         q <= lanes_of(s, taps_r);
      end
   end

`ifdef POLY_LFSR_STREAM_WORDCNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    word_cnt <= '0;
      else if (load)   word_cnt <= '0;
      else if (accept) word_cnt <= word_cnt + COUNT_W'(LANES);
   end
`endif

endmodule

// File: tb/tb_poly_lfsr_stream.sv
// Randomized, model-checked bench for poly_lfsr_stream (WIDTH=8, LANES=4, STEP=1).
// Word counter checks are included when POLY_LFSR_STREAM_WORDCNT_EN is defined.
module tb_poly_lfsr_stream;

   localparam int W  = 8;
   localparam int L  = 4;
   localparam int ST = 1;
   localparam int BW = L * W;
`ifdef POLY_LFSR_STREAM_WORDCNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 32;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic          clk;
   logic          reset_n;
   logic [W-1:0]  taps;
   logic [W-1:0]  seed;
   logic          load;
   logic          enable;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] q;
   logic          seed_err;
   logic [CW-1:0] word_cnt;

   poly_lfsr_stream #(
      .WIDTH(W), .LANES(L), .STEP(ST), .TAPS_DEFAULT(32'h8020_0003), .COUNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .taps(taps),
      .seed(seed),
      .load(load),
      .enable(enable),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q(q),
      .seed_err(seed_err)
`ifdef POLY_LFSR_STREAM_WORDCNT_EN
      ,
      .word_cnt(word_cnt)
`endif
   );

`ifndef POLY_LFSR_STREAM_WORDCNT_EN
   assign word_cnt = '0;
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // reference model state
   logic [W-1:0]  m_s;
   logic [W-1:0]  m_taps;
   logic [BW-1:0] m_q;
   logic          m_err;
   logic [CW-1:0] m_cnt;
   int            m_mode;
   logic [BW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Shift left by one, new LSB = parity of tapped bits.
   function automatic logic [W-1:0] model_step(input logic [W-1:0] x, input logic [W-1:0] t);
      int v;
      v = (int'(x) * 2 + ($countones(x & t) % 2)) % (1 << W);
      return v[W-1:0];
   endfunction

   function automatic logic [W-1:0] model_steps(input logic [W-1:0] x, input logic [W-1:0] t,
                                                input int n);
      logic [W-1:0] w;
      w = x;
      for (int i = 0; i < n; i++) w = model_step(w, t);
      return w;
   endfunction

   function automatic logic [BW-1:0] model_lanes(input logic [W-1:0] x, input logic [W-1:0] t);
      logic [BW-1:0] r;
      for (int k = 0; k < L; k++) r[k*W +: W] = model_steps(x, t, k * ST);
      return r;
   endfunction

   task automatic model_reset();
      m_s    = '1;
      m_taps = 8'h03;
      m_q    = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
      m_mode = M_IDLE;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'(m_mode != M_IDLE));
      check({tag, "_q"}, 64'(q), 64'(m_q));
      check({tag, "_seed_err"}, 64'(seed_err), 64'(m_err));
`ifdef POLY_LFSR_STREAM_WORDCNT_EN
      check({tag, "_word_cnt"}, 64'(word_cnt), 64'(m_cnt));
`endif
   endtask

   // One clock: scoreboard the beat being accepted, step the model, then compare.
   task automatic cycle(input string tag);
      logic acc;
      acc = (m_mode != M_IDLE) && out_ready && !load;
      if (acc) begin
         if (exp_q.size() > 0) check("sb_beat", 64'(q), 64'(exp_q.pop_front()));
         else                  check("sb_depth", 64'(exp_q.size()), 64'd1);
      end
      @(posedge clk);
      if (load) begin
         m_s    = (seed == '0) ? '1 : seed;
         m_taps = taps;
         m_err  = (seed == '0);
         m_cnt  = '0;
         m_mode = M_RUN;
         m_q    = model_lanes(m_s, m_taps);
         exp_q.delete();
         exp_q.push_back(m_q);
      end else if (m_mode == M_IDLE) begin
         if (enable) begin
            m_mode = M_RUN;
            m_q    = model_lanes(m_s, m_taps);
            exp_q.delete();
            exp_q.push_back(m_q);
         end
      end else begin
         if (acc) begin
            m_s   = model_steps(m_s, m_taps, L * ST);
            m_q   = model_lanes(m_s, m_taps);
            m_cnt = m_cnt + CW'(L);
            exp_q.push_back(m_q);
         end
         if (m_mode == M_RUN && !enable) m_mode = acc ? M_IDLE : M_DRAIN;
         else if (m_mode == M_DRAIN && acc) m_mode = M_IDLE;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic drive_load(input logic [W-1:0] sd, input logic [W-1:0] tp, input string tag);
      seed = sd;
      taps = tp;
      load = 1'b1;
      cycle(tag);
      load = 1'b0;
   endtask

   initial begin
      int wrap_exp[4];
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      taps      = '0;
      seed      = '0;
      load      = 1'b0;
      enable    = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      reset_n = 1'b1;
      repeat (2) cycle("idle");

      // basic load, then backpressure on the first beat
      enable = 1'b1;
      drive_load(8'h01, 8'hB8, "load1");
      check("basic_beat0", 64'(q), 64'h0804_0201);
      repeat (5) cycle("hold");
      check("hold_beat0", 64'(q), 64'h0804_0201);
      out_ready = 1'b1;
      cycle("release");
      out_ready = 1'b0;
      cycle("stall");

      // drain: enable drops while stalled
      enable = 1'b0;
      repeat (3) cycle("drain");
      out_ready = 1'b1;
      cycle("drain_acc");
      check("drain_idle", 64'(out_valid), 64'd0);
      cycle("idle2");
      enable = 1'b1;
      repeat (3) cycle("resume");

      // zero seed guard
      drive_load(8'h00, 8'hB8, "zero");
      check("zero_err", 64'(seed_err), 64'd1);
      check("zero_lane0", 64'(q[W-1:0]), 64'hFF);
      cycle("zero_run");
      drive_load(8'h01, 8'hB8, "nonzero");
      check("nonzero_err", 64'(seed_err), 64'd0);

      // load colliding with an accept
      repeat (2) cycle("pre_coll");
      drive_load(8'h5A, 8'h8E, "coll");
      check("coll_lane0", 64'(q[W-1:0]), 64'h5A);

`ifdef POLY_LFSR_STREAM_WORDCNT_EN
      check("coll_cnt", 64'(word_cnt), 64'd0);
      wrap_exp = '{4, 8, 12, 0};
      for (int i = 0; i < 4; i++) begin
         cycle("wrap");
         check("wrap_cnt", 64'(word_cnt), 64'(wrap_exp[i]));
      end
`else
      wrap_exp = '{0, 0, 0, 0};
      repeat (4) cycle("run4");
`endif

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) begin
            drive_load(($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom_range(1, 255)),
                       W'($urandom_range(0, 255)), "rand_load");
         end else begin
            cycle("rand");
         end
      end

      // asynchronous reset mid-stream, observed before any clock edge
      enable    = 1'b1;
      out_ready = 1'b1;
      cycle("pre_areset");
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("areset_valid", 64'(out_valid), 64'd0);
      check("areset_q", 64'(q), 64'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle("post_reset_idle");
      enable = 1'b1;
      repeat (4) cycle("post_reset_run");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
